// File: rtl/rob_pkg.sv
// Shared constants and entry layout for the reorder buffer.
//   DEPTH      : number of ROB entries (power of two, >= 2)
//   DATA_W     : result width, matches the ARF write data
//   REG_ADDR_W : architectural register index width
//   TAG_W      : entry tag width, derived from DEPTH
//   CNT_W      : occupancy counter width (must hold the value DEPTH)
package rob_pkg;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned TAG_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = TAG_W + 1;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / query / commit signal bundle of the reorder buffer.
//   master : the core side (dispatch, execution units, rename, ARF)
//   slave  : the reorder buffer itself
//   FLUSH                     : discard all in-flight entries
//   ALLOC_VALID/HAS_DEST/DEST : dispatch allocation request
//   ALLOC_READY/ALLOC_TAG     : allocation grant and tag (tail pointer)
//   CDB_VALID/TAG/DATA        : out-of-order completion broadcast
//   QUERY_TAGn -> DONEn/DATAn : operand lookup (combinational)
//   COMMIT_EN/REG/DATA/TAG    : registered ARF write port
//   EMPTY                     : no entries in flight
interface reorder_buffer_if import rob_pkg::*; ();

  logic                  FLUSH;
  logic                  ALLOC_VALID;
  logic                  ALLOC_HAS_DEST;
  logic [REG_ADDR_W-1:0] ALLOC_DEST;
  logic                  ALLOC_READY;
  logic [TAG_W-1:0]      ALLOC_TAG;
  logic                  CDB_VALID;
  logic [TAG_W-1:0]      CDB_TAG;
  logic [DATA_W-1:0]     CDB_DATA;
  logic [TAG_W-1:0]      QUERY_TAG1;
  logic [TAG_W-1:0]      QUERY_TAG2;
  logic                  QUERY_DONE1;
  logic                  QUERY_DONE2;
  logic [DATA_W-1:0]     QUERY_DATA1;
  logic [DATA_W-1:0]     QUERY_DATA2;
  logic                  COMMIT_EN;
  logic [REG_ADDR_W-1:0] COMMIT_REG;
  logic [DATA_W-1:0]     COMMIT_DATA;
  logic [TAG_W-1:0]      COMMIT_TAG;
  logic                  EMPTY;

  modport master (
    output FLUSH, ALLOC_VALID, ALLOC_HAS_DEST, ALLOC_DEST,
           CDB_VALID, CDB_TAG, CDB_DATA, QUERY_TAG1, QUERY_TAG2,
    input  ALLOC_READY, ALLOC_TAG, QUERY_DONE1, QUERY_DONE2,
           QUERY_DATA1, QUERY_DATA2, COMMIT_EN, COMMIT_REG,
           COMMIT_DATA, COMMIT_TAG, EMPTY
  );

  modport slave (
    input  FLUSH, ALLOC_VALID, ALLOC_HAS_DEST, ALLOC_DEST,
           CDB_VALID, CDB_TAG, CDB_DATA, QUERY_TAG1, QUERY_TAG2,
    output ALLOC_READY, ALLOC_TAG, QUERY_DONE1, QUERY_DONE2,
           QUERY_DATA1, QUERY_DATA2, COMMIT_EN, COMMIT_REG,
           COMMIT_DATA, COMMIT_TAG, EMPTY
  );

endinterface

// File: rtl/rob_entry_store.sv
// Entry array of the reorder buffer.
//   CLK, RESET            : clock, synchronous active-high reset (clears all)
//   flush                 : invalidate every entry (data left untouched)
//   alloc_en/idx/...      : write a fresh, not-done entry at the tail
//   cdb_en/idx/data       : complete a valid entry with its result
//   retire_en/idx         : invalidate the retiring head entry
//   query_idx1/2 -> ...   : raw stored state for operand lookup
//   head_idx -> head_entry: full entry at the head for retirement
module rob_entry_store import rob_pkg::*; (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  flush,
  input  logic                  alloc_en,
  input  logic [TAG_W-1:0]      alloc_idx,
  input  logic                  alloc_has_dest,
  input  logic [REG_ADDR_W-1:0] alloc_dest,
  input  logic                  cdb_en,
  input  logic [TAG_W-1:0]      cdb_idx,
  input  logic [DATA_W-1:0]     cdb_data,
  input  logic                  retire_en,
  input  logic [TAG_W-1:0]      retire_idx,
  input  logic [TAG_W-1:0]      query_idx1,
  input  logic [TAG_W-1:0]      query_idx2,
  output logic                  query_valid1,
  output logic                  query_done1,
  output logic [DATA_W-1:0]     query_data1,
  output logic                  query_valid2,
  output logic                  query_done2,
  output logic [DATA_W-1:0]     query_data2,
  input  logic [TAG_W-1:0]      head_idx,
  output rob_entry_t            head_entry
);

  rob_entry_t entries [DEPTH];

  // Port ordering: alloc only targets an invalid slot and CDB only touches
  // valid slots, so they never collide. Retire is written last so that a
  // CDB hitting the retiring head cannot resurrect it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        entries[alloc_idx].valid    <= 1'b1;
        entries[alloc_idx].done     <= 1'b0;
        entries[alloc_idx].has_dest <= alloc_has_dest;
        entries[alloc_idx].dest     <= alloc_dest;
        entries[alloc_idx].data     <= '0;
      end
      if (cdb_en && entries[cdb_idx].valid) begin
        entries[cdb_idx].done <= 1'b1;
        entries[cdb_idx].data <= cdb_data;
      end
      if (retire_en) begin
        entries[retire_idx].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    query_valid1 = entries[query_idx1].valid;
    query_done1  = entries[query_idx1].done;
    query_data1  = entries[query_idx1].data;
    query_valid2 = entries[query_idx2].valid;
    query_done2  = entries[query_idx2].done;
    query_data2  = entries[query_idx2].data;
    head_entry   = entries[head_idx];
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage: allocates entries at dispatch, accepts out-of-order
// completion from the CDB, retires one completed head entry per cycle into
// the ARF write port and serves two tag-indexed operand lookups.
//   CLK   : clock, all state on the rising edge
//   RESET : synchronous, active-high
//   rob   : reorder_buffer_if.slave (alloc, CDB, query, commit, FLUSH, EMPTY)
module reorder_buffer import rob_pkg::*; (
  input  logic              CLK,
  input  logic              RESET,
  reorder_buffer_if.slave   rob
);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              alloc_fire;
  logic              retire;
  rob_entry_t        head_entry;
  logic              q_valid1;
  logic              q_done1;
  logic [DATA_W-1:0] q_data1;
  logic              q_valid2;
  logic              q_done2;
  logic [DATA_W-1:0] q_data2;
  logic              byp1;
  logic              byp2;

  // Readiness comes from the registered count only: a full ROB refuses
  // allocation even when the head retires in the same cycle.
  assign rob.ALLOC_READY = (count != CNT_W'(DEPTH));
  assign rob.ALLOC_TAG   = tail;
  assign rob.EMPTY       = (count == '0);

  assign alloc_fire = rob.ALLOC_VALID && rob.ALLOC_READY;
  assign retire     = head_entry.valid && head_entry.done;

  rob_entry_store u_store (
    .CLK            (CLK),
    .RESET          (RESET),
    .flush          (rob.FLUSH),
    .alloc_en       (alloc_fire),
    .alloc_idx      (tail),
    .alloc_has_dest (rob.ALLOC_HAS_DEST),
    .alloc_dest     (rob.ALLOC_DEST),
    .cdb_en         (rob.CDB_VALID),
    .cdb_idx        (rob.CDB_TAG),
    .cdb_data       (rob.CDB_DATA),
    .retire_en      (retire),
    .retire_idx     (head),
    .query_idx1     (rob.QUERY_TAG1),
    .query_idx2     (rob.QUERY_TAG2),
    .query_valid1   (q_valid1),
    .query_done1    (q_done1),
    .query_data1    (q_data1),
    .query_valid2   (q_valid2),
    .query_done2    (q_done2),
    .query_data2    (q_data2),
    .head_idx       (head),
    .head_entry     (head_entry)
  );

  // Pointers and occupancy; FLUSH acts like RESET here and beats alloc/retire.
  always_ff @(posedge CLK) begin
    if (RESET || rob.FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) tail <= tail + TAG_W'(1);
      if (retire)     head <= head + TAG_W'(1);
      case ({alloc_fire, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Commit port: registered, one-cycle enable per retirement; the payload
  // holds its last value when nothing retires.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rob.COMMIT_EN   <= 1'b0;
      rob.COMMIT_REG  <= '0;
      rob.COMMIT_DATA <= '0;
      rob.COMMIT_TAG  <= '0;
    end else if (rob.FLUSH) begin
      rob.COMMIT_EN <= 1'b0;
    end else if (retire) begin
      rob.COMMIT_EN   <= head_entry.has_dest && (head_entry.dest != '0);
      rob.COMMIT_REG  <= head_entry.dest;
      rob.COMMIT_DATA <= head_entry.data;
      rob.COMMIT_TAG  <= head;
    end else begin
      rob.COMMIT_EN <= 1'b0;
    end
  end

  // Operand lookup with same-cycle CDB bypass; the bypassed value wins over
  // stored data so a re-broadcast is visible immediately.
  always_comb begin
    byp1 = rob.CDB_VALID && (rob.CDB_TAG == rob.QUERY_TAG1);
    byp2 = rob.CDB_VALID && (rob.CDB_TAG == rob.QUERY_TAG2);
    rob.QUERY_DONE1 = q_valid1 && (q_done1 || byp1);
    rob.QUERY_DONE2 = q_valid2 && (q_done2 || byp2);
    rob.QUERY_DATA1 = '0;
    rob.QUERY_DATA2 = '0;
    if (rob.QUERY_DONE1) rob.QUERY_DATA1 = byp1 ? rob.CDB_DATA : q_data1;
    if (rob.QUERY_DONE2) rob.QUERY_DATA2 = byp2 ? rob.CDB_DATA : q_data2;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard: stimulus
// pushes expected ARF writes, a negedge monitor pops and compares them.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_err;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    logic [2:0]  t;
  } exp_t;

  exp_t sb[$];

  reorder_buffer_if rob ();

  reorder_buffer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rob   (rob)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [31:0] d, input logic [2:0] t);
    exp_t e;
    e.r = r;
    e.d = d;
    e.t = t;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic alloc(input logic hd, input logic [3:0] dest);
    rob.ALLOC_VALID    = 1'b1;
    rob.ALLOC_HAS_DEST = hd;
    rob.ALLOC_DEST     = dest;
    tick();
    rob.ALLOC_VALID = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    rob.CDB_VALID = 1'b1;
    rob.CDB_TAG   = tag;
    rob.CDB_DATA  = data;
    tick();
    rob.CDB_VALID = 1'b0;
  endtask

  // Commit monitor
  always @(negedge CLK) begin : mon
    exp_t e;
    if (rob.COMMIT_EN === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: got reg=%0d data=%0h tag=%0d required no commit",
                 rob.COMMIT_REG, rob.COMMIT_DATA, rob.COMMIT_TAG);
      end else begin
        e = sb.pop_front();
        if (rob.COMMIT_REG !== e.r || rob.COMMIT_DATA !== e.d || rob.COMMIT_TAG !== e.t) begin
          n_err++;
          $display("FAIL commit_payload: got reg=%0d data=%0h tag=%0d required reg=%0d data=%0h tag=%0d",
                   rob.COMMIT_REG, rob.COMMIT_DATA, rob.COMMIT_TAG, e.r, e.d, e.t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b0;
    rob.FLUSH = 1'b0;
    rob.ALLOC_VALID = 1'b0;
    rob.ALLOC_HAS_DEST = 1'b0;
    rob.ALLOC_DEST = '0;
    rob.CDB_VALID = 1'b0;
    rob.CDB_TAG = '0;
    rob.CDB_DATA = '0;
    rob.QUERY_TAG1 = '0;
    rob.QUERY_TAG2 = '0;

    // 1) reset state and single alloc -> commit latency
    do_reset();
    chk("rst_ready", 32'(rob.ALLOC_READY), 1);
    chk("rst_tag", 32'(rob.ALLOC_TAG), 0);
    chk("rst_empty", 32'(rob.EMPTY), 1);
    chk("rst_qdone", 32'(rob.QUERY_DONE1), 0);
    chk("rst_commit_en", 32'(rob.COMMIT_EN), 0);
    chk("rst_commit_reg", 32'(rob.COMMIT_REG), 0);
    chk("rst_commit_data", rob.COMMIT_DATA, 0);
    chk("rst_commit_tag", 32'(rob.COMMIT_TAG), 0);
    alloc(1'b1, 4'd5);
    chk("t1_not_empty", 32'(rob.EMPTY), 0);
    push(4'd5, 32'hDEADBEEF, 3'd0);
    cdb(3'd0, 32'hDEADBEEF);
    chk("t1_no_commit_yet", 32'(rob.COMMIT_EN), 0);
    tick();
    chk("t1_commit_en", 32'(rob.COMMIT_EN), 1);
    chk("t1_empty_after", 32'(rob.EMPTY), 1);
    tick();
    chk("t1_commit_pulse", 32'(rob.COMMIT_EN), 0);

    // 2) out-of-order completion, in-order commit
    do_reset();
    alloc(1'b1, 4'd1);
    alloc(1'b1, 4'd2);
    alloc(1'b1, 4'd3);
    push(4'd1, 32'h11, 3'd0);
    push(4'd2, 32'h22, 3'd1);
    push(4'd3, 32'h33, 3'd2);
    cdb(3'd2, 32'h33);
    cdb(3'd1, 32'h22);
    cdb(3'd0, 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_consecutive_commit", 32'(rob.COMMIT_EN), 1);
    end
    tick();
    chk("t2_commit_done", 32'(rob.COMMIT_EN), 0);
    chk("t2_empty", 32'(rob.EMPTY), 1);

    // 3) full, ignored alloc, no bypass from retire, wrap-around
    do_reset();
    rob.ALLOC_VALID = 1'b1;
    rob.ALLOC_HAS_DEST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_fill_tag", 32'(rob.ALLOC_TAG), 32'(i));
      rob.ALLOC_DEST = 4'(i + 1);
      tick();
    end
    chk("t3_full_ready", 32'(rob.ALLOC_READY), 0);
    chk("t3_full_tag", 32'(rob.ALLOC_TAG), 0);
    tick();
    chk("t3_ignored_tag", 32'(rob.ALLOC_TAG), 0);
    chk("t3_ignored_ready", 32'(rob.ALLOC_READY), 0);
    push(4'd1, 32'hA0, 3'd0);
    rob.CDB_VALID = 1'b1;
    rob.CDB_TAG = 3'd0;
    rob.CDB_DATA = 32'hA0;
    tick();
    rob.CDB_VALID = 1'b0;
    chk("t3_retire_cycle_ready", 32'(rob.ALLOC_READY), 0);
    tick();
    rob.ALLOC_VALID = 1'b0;
    chk("t3_ready_after_retire", 32'(rob.ALLOC_READY), 1);
    chk("t3_wrap_tag", 32'(rob.ALLOC_TAG), 0);
    alloc(1'b1, 4'd9);
    chk("t3_full_again", 32'(rob.ALLOC_READY), 0);
    chk("t3_tail_after_wrap", 32'(rob.ALLOC_TAG), 1);

    // 4) dest 0 and no-dest entries retire silently
    do_reset();
    alloc(1'b1, 4'd0);
    alloc(1'b0, 4'd7);
    cdb(3'd0, 32'h1234);
    cdb(3'd1, 32'h5678);
    chk("t4_not_empty", 32'(rob.EMPTY), 0);
    tick();
    tick();
    chk("t4_empty", 32'(rob.EMPTY), 1);
    chk("t4_commit_en", 32'(rob.COMMIT_EN), 0);

    // 5) query bypass and invalid-tag lookup
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b1, 4'(i + 4));
    rob.QUERY_TAG1 = 3'd3;
    rob.QUERY_TAG2 = 3'd5;
    #1;
    chk("t5_q1_before", 32'(rob.QUERY_DONE1), 0);
    rob.CDB_VALID = 1'b1;
    rob.CDB_TAG = 3'd3;
    rob.CDB_DATA = 32'h55;
    #1;
    chk("t5_bypass_done", 32'(rob.QUERY_DONE1), 1);
    chk("t5_bypass_data", rob.QUERY_DATA1, 32'h55);
    chk("t5_invalid_done", 32'(rob.QUERY_DONE2), 0);
    chk("t5_invalid_data", rob.QUERY_DATA2, 0);
    tick();
    rob.CDB_VALID = 1'b0;
    #1;
    chk("t5_stored_done", 32'(rob.QUERY_DONE1), 1);
    chk("t5_stored_data", rob.QUERY_DATA1, 32'h55);
    cdb(3'd6, 32'h66);
    rob.QUERY_TAG2 = 3'd6;
    #1;
    chk("t5_dropped_cdb", 32'(rob.QUERY_DONE2), 0);

    // 6) flush overrides same-cycle CDB
    do_reset();
    alloc(1'b1, 4'd1);
    alloc(1'b1, 4'd2);
    alloc(1'b1, 4'd3);
    rob.FLUSH = 1'b1;
    rob.CDB_VALID = 1'b1;
    rob.CDB_TAG = 3'd0;
    rob.CDB_DATA = 32'hBAD;
    tick();
    rob.FLUSH = 1'b0;
    rob.CDB_VALID = 1'b0;
    chk("t6_empty", 32'(rob.EMPTY), 1);
    chk("t6_tag", 32'(rob.ALLOC_TAG), 0);
    rob.QUERY_TAG1 = 3'd0;
    #1;
    chk("t6_q_invalid", 32'(rob.QUERY_DONE1), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_no_commit", 32'(rob.COMMIT_EN), 0);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
